// File: rtl/pushbutton_pio_pkg.sv
// Shared constants for the push-button PIO: register addresses, edge modes,
// and the edge-qualification helper used by the capture logic.
package pushbutton_pio_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_RAW  = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    // True when a stable-level transition counts as a capture event for the mode.
    function automatic logic edge_qualifies(input int mode, input logic rise, input logic fall);
        logic q;
        case (mode)
            EDGE_RISE: q = rise;
            EDGE_FALL: q = fall;
            EDGE_ANY:  q = rise | fall;
            default:   q = 1'b0;
        endcase
        return q;
    endfunction

endpackage

// File: rtl/pb_debounce.sv
// One button channel: 2-flop synchroniser, disagreement counter and stable level,
// with single-cycle rise/fall strobes asserted on the edge where stable updates.
module pb_debounce
    import pushbutton_pio_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = 500000,
    parameter logic RESET_LEVEL     = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic in_bit,
    output logic sync_bit,
    output logic stable_bit,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_r;
    logic          sync2_r;
    logic          stable_r;
    logic [CW-1:0] cnt_r;
    logic          update_s;

    // Stable moves on this edge only after DEBOUNCE_CYCLES disagreeing samples.
    assign update_s   = (sync2_r != stable_r) && (cnt_r == CNT_LAST);
    assign rise       = update_s & sync2_r;
    assign fall       = update_s & ~sync2_r;
    assign sync_bit   = sync2_r;
    assign stable_bit = stable_r;

    // Synchroniser, debounce counter and stable level.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r  <= RESET_LEVEL;
            sync2_r  <= RESET_LEVEL;
            stable_r <= RESET_LEVEL;
            cnt_r    <= '0;
        end else begin
            sync1_r <= in_bit;
            sync2_r <= sync1_r;
            if (sync2_r == stable_r) begin
                cnt_r <= '0;
            end else if (cnt_r == CNT_LAST) begin
                stable_r <= sync2_r;
                cnt_r    <= '0;
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
        end
    end

endmodule

// File: rtl/pushbutton_edge_pio.sv
// Avalon-MM push-button PIO: debounced level, raw level, interrupt mask and a
// write-1-to-clear edge capture register driving one level interrupt.
module pushbutton_edge_pio
    import pushbutton_pio_pkg::*;
#(
    parameter int               WIDTH           = 4,
    parameter int               DEBOUNCE_CYCLES = 500000,
    parameter int               EDGE_MODE       = EDGE_FALL,
    parameter logic [WIDTH-1:0] RESET_LEVEL     = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] raw_s;
    logic [WIDTH-1:0] stable_s;
    logic [WIDTH-1:0] rise_s;
    logic [WIDTH-1:0] fall_s;
    logic [WIDTH-1:0] set_s;
    logic [WIDTH-1:0] clr_s;
    logic [WIDTH-1:0] capture_next_s;
    logic [31:0]      rd_next_s;
    logic             wr_s;
    logic             unused_s;

    logic [WIDTH-1:0] irq_mask_r;
    logic [WIDTH-1:0] edge_capture_r;
    logic [31:0]      readdata_r;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        pb_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_LEVEL     (RESET_LEVEL[i])
        ) u_debounce (
            .clk        (clk),
            .reset      (reset),
            .in_bit     (in_port[i]),
            .sync_bit   (raw_s[i]),
            .stable_bit (stable_s[i]),
            .rise       (rise_s[i]),
            .fall       (fall_s[i])
        );
    end

    assign wr_s     = chipselect & ~write_n;
    assign unused_s = &{1'b0, writedata};

    // Capture next-state: a new qualifying edge beats a same-cycle W1C clear.
    always_comb begin
        set_s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            set_s[i] = edge_qualifies(EDGE_MODE, rise_s[i], fall_s[i]);
        end
        if (wr_s && (address == ADDR_EDGE)) begin
            clr_s = writedata[WIDTH-1:0];
        end else begin
            clr_s = '0;
        end
        capture_next_s = (edge_capture_r & ~clr_s) | set_s;
    end

    // Read mux; unused upper bits are zero-extended.
    always_comb begin
        rd_next_s = 32'd0;
        case (address)
            ADDR_DATA: rd_next_s = 32'(stable_s);
            ADDR_RAW:  rd_next_s = 32'(raw_s);
            ADDR_MASK: rd_next_s = 32'(irq_mask_r);
            ADDR_EDGE: rd_next_s = 32'(edge_capture_r);
            default:   rd_next_s = 32'd0;
        endcase
    end

    // Register file and registered read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_mask_r     <= '0;
            edge_capture_r <= '0;
            readdata_r     <= 32'd0;
        end else begin
            if (wr_s && (address == ADDR_MASK)) begin
                irq_mask_r <= writedata[WIDTH-1:0];
            end else begin
                irq_mask_r <= irq_mask_r;
            end
            edge_capture_r <= capture_next_s;
            readdata_r     <= rd_next_s;
        end
    end

    assign readdata = readdata_r;
    assign irq      = |(edge_capture_r & irq_mask_r);

endmodule

// File: tb/tb_pushbutton_edge_pio.sv
// Bench for pushbutton_edge_pio: falling-edge and any-edge instances share stimulus
// and are compared every cycle against a sliding-window reference model.
module tb_pushbutton_edge_pio;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [31:0] rd_fall, rd_any;
    logic        irq_fall, irq_any;

    int checks = 0;
    int errors = 0;

    // Reference state
    logic [3:0]  m_sync1, m_sync2, m_stable, m_mask, m_cap_fall, m_cap_any;
    logic [31:0] m_rd_fall, m_rd_any;
    logic [3:0]  hist[$];

    always #5 clk = ~clk;

    pushbutton_edge_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(D), .EDGE_MODE(1), .RESET_LEVEL(4'hF)) u_dut_fall (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .in_port(in_port), .readdata(rd_fall), .irq(irq_fall));

    pushbutton_edge_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(D), .EDGE_MODE(2), .RESET_LEVEL(4'hF)) u_dut_any (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .in_port(in_port), .readdata(rd_any), .irq(irq_any));

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock edge: advance the model from pre-edge inputs, then compare outputs.
    task automatic step();
        logic [3:0] nstable, rise, fall, clr, mask_n;
        logic       all_diff;
        @(posedge clk);
        if (reset) begin
            m_sync1 = 4'hF; m_sync2 = 4'hF; m_stable = 4'hF;
            m_mask = 4'h0; m_cap_fall = 4'h0; m_cap_any = 4'h0;
            m_rd_fall = 32'd0; m_rd_any = 32'd0;
            hist.delete();
        end else begin
            case (address)
                2'd0:    begin m_rd_fall = {28'd0, m_stable}; m_rd_any = {28'd0, m_stable}; end
                2'd1:    begin m_rd_fall = {28'd0, m_sync2};  m_rd_any = {28'd0, m_sync2};  end
                2'd2:    begin m_rd_fall = {28'd0, m_mask};   m_rd_any = {28'd0, m_mask};   end
                default: begin m_rd_fall = {28'd0, m_cap_fall}; m_rd_any = {28'd0, m_cap_any}; end
            endcase
            // Stable flips once the last D synchronised samples all disagree with it.
            hist.push_back(m_sync2);
            if (hist.size() > D) void'(hist.pop_front());
            nstable = m_stable;
            for (int i = 0; i < 4; i++) begin
                if (hist.size() == D) begin
                    all_diff = 1'b1;
                    foreach (hist[k]) if (hist[k][i] == m_stable[i]) all_diff = 1'b0;
                    if (all_diff) nstable[i] = ~m_stable[i];
                end
            end
            rise = nstable & ~m_stable;
            fall = ~nstable & m_stable;
            clr = (chipselect && !write_n && address == 2'd3) ? writedata[3:0] : 4'h0;
            mask_n = (chipselect && !write_n && address == 2'd2) ? writedata[3:0] : m_mask;
            m_cap_fall = (m_cap_fall & ~clr) | fall;
            m_cap_any  = (m_cap_any & ~clr) | rise | fall;
            m_mask = mask_n;
            m_stable = nstable;
            m_sync2 = m_sync1;
            m_sync1 = in_port;
        end
        #1;
        check_eq("rd_fall",  rd_fall,  m_rd_fall);
        check_eq("irq_fall", {31'd0, irq_fall}, {31'd0, |(m_cap_fall & m_mask)});
        check_eq("rd_any",   rd_any,   m_rd_any);
        check_eq("irq_any",  {31'd0, irq_any},  {31'd0, |(m_cap_any & m_mask)});
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
        step();
        chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
    endtask

    task automatic settle_and_clear();
        in_port = 4'hF;
        steps(8);
        bus_write(2'd3, 32'hF);
    endtask

    initial begin
        reset = 1'b1; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
        writedata = 32'd0; in_port = 4'hF;
        m_sync1 = 4'hF; m_sync2 = 4'hF; m_stable = 4'hF; m_mask = 4'h0;
        m_cap_fall = 4'h0; m_cap_any = 4'h0; m_rd_fall = 32'd0; m_rd_any = 32'd0;
        steps(3);
        reset = 1'b0;

        // Idle reads of DATA, MASK, EDGE
        address = 2'd0; step(); step();
        check_eq("idle_data", rd_fall, 32'hF);
        address = 2'd2; step();
        check_eq("idle_mask", rd_fall, 32'h0);
        address = 2'd3; step();
        check_eq("idle_edge", rd_fall, 32'h0);

        // Press bit 2 with mask 4
        bus_write(2'd2, 32'h4);
        in_port = 4'hB; address = 2'd3;
        steps(6);
        check_eq("press_irq", {31'd0, irq_fall}, 32'd1);
        step();
        check_eq("press_cap", rd_fall, 32'h4);
        address = 2'd0; step();
        check_eq("press_data", rd_fall, 32'hB);
        bus_write(2'd2, 32'h0);
        settle_and_clear();

        // 3-cycle glitch is rejected, 4-cycle pulse is captured
        in_port = 4'hD; steps(3); in_port = 4'hF; steps(8);
        address = 2'd3; step();
        check_eq("glitch_cap", rd_fall, 32'h0);
        in_port = 4'hD; steps(4); in_port = 4'hF; steps(8);
        step();
        check_eq("pulse_cap", rd_fall, 32'h2);
        check_eq("pulse_irq", {31'd0, irq_fall}, 32'd0);
        bus_write(2'd3, 32'hF);

        // Partial W1C with capture 6 pending
        in_port = 4'h9; steps(8);
        bus_write(2'd2, 32'hF);
        bus_write(2'd3, 32'h2);
        check_eq("w1c_irq_hold", {31'd0, irq_fall}, 32'd1);
        address = 2'd3; step();
        check_eq("w1c_cap4", rd_fall, 32'h4);
        bus_write(2'd3, 32'h4);
        check_eq("w1c_irq_drop", {31'd0, irq_fall}, 32'd0);
        settle_and_clear();

        // W1C collides with a new fall on bit 0: set wins
        in_port = 4'hE; steps(5);
        bus_write(2'd3, 32'h1);
        address = 2'd3; step();
        check_eq("collide_fall", rd_fall, 32'h1);
        check_eq("collide_any",  rd_any,  32'h1);
        settle_and_clear();
        address = 2'd3; step();
        check_eq("release_any", rd_any, 32'h0);

        // Reset mid-debounce
        in_port = 4'hE; steps(4);
        reset = 1'b1; step(); reset = 1'b0;
        check_eq("rst_rd", rd_fall, 32'h0);
        check_eq("rst_irq", {31'd0, irq_fall}, 32'd0);
        address = 2'd0; steps(6);
        check_eq("rst_pending", rd_fall, 32'hF);
        steps(3);
        check_eq("rst_settled", rd_fall, 32'hE);
        settle_and_clear();

        // Randomised traffic
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 5) == 0) in_port[$urandom_range(0, 3)] ^= 1'b1;
            address    = 2'($urandom_range(0, 3));
            chipselect = ($urandom_range(0, 3) == 0);
            write_n    = ($urandom_range(0, 1) == 0);
            writedata  = $urandom;
            reset      = ($urandom_range(0, 299) == 0);
            step();
        end
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
